fb_scanout: RTL

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_scanout.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: 1-bit framebuffer with 640x480@60 VGA scanout.
// Ports: clk/reset (sync, active high); x, y, pixel_color and
// pixel_write form the write port; VGA_* drive the DAC and connector;
// frame_start pulses once per frame when the scan returns to (0,0).

module fb_scanout #(
    parameter int HRES = 640,
    parameter int VRES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       pixel_color,
    input  logic       pixel_write,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int DEPTH = HRES * VRES;
    localparam int AW    = $clog2(DEPTH);

    // Horizontal and vertical timing, in pixel periods and lines.
    localparam logic [9:0] H_VIS    = 10'(HRES);
    localparam logic [9:0] H_SY_BEG = 10'(HRES + 16);
    localparam logic [9:0] H_SY_END = 10'(HRES + 16 + 96);
    localparam logic [9:0] H_LAST   = 10'(HRES + 160 - 1);
    localparam logic [9:0] V_VIS    = 10'(VRES);
    localparam logic [9:0] V_SY_BEG = 10'(VRES + 10);
    localparam logic [9:0] V_SY_END = 10'(VRES + 10 + 2);
    localparam logic [9:0] V_LAST   = 10'(VRES + 45 - 1);

    localparam logic [9:0] X_LIM = 10'(HRES);
    localparam logic [8:0] Y_LIM = 9'(VRES);

    // Timing state
    logic       pix_en_q, pix_en_d;
    logic       vga_clk_q, vga_clk_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       frame_start_q, frame_start_d;

    // Stage 1: sync/visible flags aligned with the memory read
    logic       hs_s1_q, hs_s1_d;
    logic       vs_s1_q, vs_s1_d;
    logic       vis_s1_q, vis_s1_d;

    // Stage 2: registered outputs
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic [7:0] rgb_q, rgb_d;

    // Pixel memory
    logic          mem [DEPTH];
    logic          rd_data_q;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          we;
    logic          visible;
    logic          h_end;
    logic          v_end;

    always_comb begin
        we    = pixel_write && !reset && (x < X_LIM) && (y < Y_LIM);
        waddr = AW'(y) * AW'(HRES) + AW'(x);
    end

    always_comb begin
        pix_en_d      = ~pix_en_q;
        // VGA_CLK rises on exactly the edges where the counters advance
        vga_clk_d     = pix_en_q;
        h_end         = (hcount_q == H_LAST);
        v_end         = (vcount_q == V_LAST);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = pix_en_q && h_end && v_end;
        if (pix_en_q) begin
            if (h_end) begin
                hcount_d = '0;
                vcount_d = v_end ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        visible = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        raddr   = visible ? AW'(vcount_q) * AW'(HRES) + AW'(hcount_q)
                          : '0;

        hs_s1_d  = !((hcount_q >= H_SY_BEG) && (hcount_q < H_SY_END));
        vs_s1_d  = !((vcount_q >= V_SY_BEG) && (vcount_q < V_SY_END));
        vis_s1_d = visible;

        hs_d      = hs_s1_q;
        vs_d      = vs_s1_q;
        blank_n_d = vis_s1_q;
        rgb_d     = (vis_s1_q && rd_data_q) ? 8'hFF : 8'h00;
    end

    // Memory is deliberately left out of reset; read-before-write
    // ordering returns the old value on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= pixel_color;
        end
        rd_data_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            vis_s1_q      <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            rgb_q         <= '0;
        end else begin
            pix_en_q      <= pix_en_d;
            vga_clk_q     <= vga_clk_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            vis_s1_q      <= vis_s1_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            rgb_q         <= rgb_d;
        end
    end

    assign frame_start = frame_start_q;
    assign VGA_R       = rgb_q;
    assign VGA_G       = rgb_q;
    assign VGA_B       = rgb_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;

endmodule
